// File: rtl/dmem_responder.sv
// Data-memory responder: a small word-addressed RAM behind a req/ack
// handshake with a configurable number of wait states before each response.
// Misaligned or out-of-range requests complete immediately with o_err set.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_arst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_ready,
   output logic        o_ack,
   output logic [31:0] o_rdata,
   output logic        o_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   waitCnt_q, waitCnt_d;
   logic            we_q;
   logic            err_q;
   logic [AW-1:0]   addr_q;
   logic [31:0]     wdata_q;
   logic [31:0]     rdata_q;
   logic [31:0]     mem [DEPTH_WORDS];

   logic            reqErr;
   logic            accept;
   logic            enterResp;
   logic            commitWe;
   logic            commitErr;
   logic [AW-1:0]   commitAddr;
   logic [31:0]     commitWdata;

   // A request is bad when it is not word aligned or points past the last word.
   always_comb begin
      reqErr = (i_addr[1:0] != 2'b00) ||
               ({2'b00, i_addr[31:2]} >= 32'(DEPTH_WORDS));
   end

   // Next-state logic. When the transition into RESP happens straight from
   // IDLE the live request fields are used, otherwise the captured copies;
   // the commit* signals present whichever applies to the memory and read
   // data registers so both paths share one write/read port.
   always_comb begin
      state_d     = state_q;
      waitCnt_d   = waitCnt_q;
      accept      = 1'b0;
      enterResp   = 1'b0;
      commitWe    = we_q;
      commitErr   = err_q;
      commitAddr  = addr_q;
      commitWdata = wdata_q;
      case (state_q)
         IDLE: begin
            if (i_req) begin
               accept      = 1'b1;
               commitWe    = i_we;
               commitErr   = reqErr;
               commitAddr  = i_addr[AW+1:2];
               commitWdata = i_wdata;
               if (reqErr || (WAIT_CYCLES == 0)) begin
                  state_d   = RESP;
                  enterResp = 1'b1;
               end else begin
                  state_d   = WAIT;
                  waitCnt_d = CW'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (waitCnt_q == '0) begin
               state_d   = RESP;
               enterResp = 1'b1;
            end else begin
               waitCnt_d = waitCnt_q - CW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state, captured request and read data. Reset drops any request
   // in flight and clears the visible response registers.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q   <= IDLE;
         waitCnt_q <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         if (accept) begin
            we_q    <= i_we;
            err_q   <= reqErr;
            addr_q  <= i_addr[AW+1:2];
            wdata_q <= i_wdata;
         end
         if (enterResp && !commitWe && !commitErr) begin
            rdata_q <= mem[commitAddr];
         end
      end
   end

   // Storage array; deliberately not reset. Writes land on the edge that
   // enters RESP and are blocked while reset is held so an aborted write
   // never reaches the array.
   always_ff @(posedge i_clk) begin
      if (!i_arst && enterResp && commitWe && !commitErr) begin
         mem[commitAddr] <= commitWdata;
      end
   end

   assign o_ready = (state_q == IDLE);
   assign o_ack   = (state_q == RESP);
   assign o_err   = (state_q == RESP) && err_q;
   assign o_rdata = rdata_q;

endmodule
